// File: rtl/instr_encoder_pkg.sv
// RV32I definitions shared by the encoder and the main decoder checks.
// Covers class codes, 7-bit opcodes, error codes, and class-to-opcode/format helpers.
package instr_encoder_pkg;

    typedef enum logic [3:0] {
        CLS_LOAD   = 4'd0,
        CLS_STORE  = 4'd1,
        CLS_RTYPE  = 4'd2,
        CLS_BRANCH = 4'd3,
        CLS_ITYPE  = 4'd4,
        CLS_JAL    = 4'd5,
        CLS_AUIPC  = 4'd6,
        CLS_LUI    = 4'd7,
        CLS_JALR   = 4'd8
    } instr_class_e;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_J, FMT_U, FMT_X
    } fmt_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_ILLEGAL  = 2'b01,
        ERR_MISALIGN = 2'b10,
        ERR_RANGE    = 2'b11
    } err_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    function automatic logic [6:0] class_opcode(input instr_class_e cls);
        case (cls)
            CLS_LOAD:   return OPC_LOAD;
            CLS_STORE:  return OPC_STORE;
            CLS_RTYPE:  return OPC_RTYPE;
            CLS_BRANCH: return OPC_BRANCH;
            CLS_ITYPE:  return OPC_ITYPE;
            CLS_JAL:    return OPC_JAL;
            CLS_AUIPC:  return OPC_AUIPC;
            CLS_LUI:    return OPC_LUI;
            CLS_JALR:   return OPC_JALR;
            default:    return 7'b0000000;
        endcase
    endfunction

    function automatic fmt_e class_fmt(input instr_class_e cls);
        case (cls)
            CLS_LOAD, CLS_ITYPE, CLS_JALR: return FMT_I;
            CLS_STORE:                     return FMT_S;
            CLS_RTYPE:                     return FMT_R;
            CLS_BRANCH:                    return FMT_B;
            CLS_JAL:                       return FMT_J;
            CLS_AUIPC, CLS_LUI:            return FMT_U;
            default:                       return FMT_X;
        endcase
    endfunction

endpackage

// File: rtl/instr_encoder_imm_packer.sv
// Places a sign-extended byte immediate (or R-type funct7) into its RV32I bit positions.
// Combinational; flags misalignment, and with IMM_RANGE_CHECK_EN also unrepresentable immediates.
module imm_packer
    import instr_encoder_pkg::*;
(
    input  instr_class_e i_class,
    input  logic [2:0]   i_funct3,
    input  logic         i_funct7b5,
    input  logic [31:0]  i_imm,
    output logic [31:0]  o_imm_bits,
    output logic         o_misaligned,
    output logic         o_range_err
);
    fmt_e       w_fmt;
    logic       w_shift;
    logic [6:0] w_funct7;

    assign w_fmt    = class_fmt(i_class);
    assign w_shift  = (i_class == CLS_ITYPE) && ((i_funct3 == 3'b001) || (i_funct3 == 3'b101));
    assign w_funct7 = {1'b0, i_funct7b5, 5'b00000};

    assign o_misaligned = ((w_fmt == FMT_B) || (w_fmt == FMT_J)) && i_imm[0];

    always_comb begin
        o_imm_bits = 32'h0;
        case (w_fmt)
            FMT_I:   o_imm_bits = w_shift ? {w_funct7, i_imm[4:0], 20'h0} : {i_imm[11:0], 20'h0};
            FMT_S:   o_imm_bits = {i_imm[11:5], 13'h0, i_imm[4:0], 7'h0};
            FMT_B:   o_imm_bits = {i_imm[12], i_imm[10:5], 13'h0, i_imm[4:1], i_imm[11], 7'h0};
            FMT_J:   o_imm_bits = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], 12'h0};
            FMT_U:   o_imm_bits = {i_imm[31:12], 12'h0};
            FMT_R:   o_imm_bits = {w_funct7, 25'h0};
            default: o_imm_bits = 32'h0;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // Representable iff every bit above the format's sign bit matches it.
    logic w_fit_i;
    logic w_fit_b;
    logic w_fit_j;

    assign w_fit_i = (&i_imm[31:11]) || !(|i_imm[31:11]);
    assign w_fit_b = (&i_imm[31:12]) || !(|i_imm[31:12]);
    assign w_fit_j = (&i_imm[31:20]) || !(|i_imm[31:20]);

    always_comb begin
        o_range_err = 1'b0;
        case (w_fmt)
            FMT_I, FMT_S: o_range_err = !w_fit_i;
            FMT_B:        o_range_err = !w_fit_b;
            FMT_J:        o_range_err = !w_fit_j;
            FMT_U:        o_range_err = |i_imm[11:0];
            default:      o_range_err = 1'b0;
        endcase
    end
`else
    assign o_range_err = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: fields in, {word address, instruction} out through a 2-entry FIFO.
// Latency 1 cycle into an empty FIFO; in_ready = !full from the registered count. Optional IMM_RANGE_CHECK_EN.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_class,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7b5,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_instr,
    output logic              err_sticky,
    output logic [1:0]        err_code
);
    localparam logic [ADDR_W-1:0] L_BASE = ADDR_W'(BASE_ADDR);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       instr;
    } entry_t;

    instr_class_e      w_class;
    fmt_e              w_fmt;
    logic [31:0]       w_imm_bits;
    logic              w_misaligned;
    logic              w_range_err;
    logic              w_illegal;
    logic              w_use_rd;
    logic              w_use_rs1;
    logic              w_use_rs2;
    logic [2:0]        w_funct3;
    logic [31:0]       w_fields;
    logic [31:0]       w_instr;
    logic              w_accept;
    logic              w_reject;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_cur_addr;

    entry_t            r_mem [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;
    logic [ADDR_W-1:0] r_addr;
    logic              r_err_sticky;
    logic [1:0]        r_err_code;

    assign w_class = instr_class_e'(in_class);
    assign w_fmt   = class_fmt(w_class);

    imm_packer u_imm_packer (
        .i_class      (w_class),
        .i_funct3     (in_funct3),
        .i_funct7b5   (in_funct7b5),
        .i_imm        (in_imm),
        .o_imm_bits   (w_imm_bits),
        .o_misaligned (w_misaligned),
        .o_range_err  (w_range_err)
    );

    // Register fields a format does not carry stay zero so the immediate can be OR-ed in.
    assign w_illegal = (w_fmt == FMT_X);
    assign w_use_rd  = w_fmt inside {FMT_R, FMT_I, FMT_J, FMT_U};
    assign w_use_rs1 = w_fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
    assign w_use_rs2 = w_fmt inside {FMT_R, FMT_S, FMT_B};
    assign w_funct3  = (w_class == CLS_JALR) ? 3'b000 : in_funct3;

    assign w_fields = {7'b0000000,
                       w_use_rs2 ? in_rs2   : 5'b00000,
                       w_use_rs1 ? in_rs1   : 5'b00000,
                       w_use_rs1 ? w_funct3 : 3'b000,
                       w_use_rd  ? in_rd    : 5'b00000,
                       class_opcode(w_class)};
    assign w_instr  = w_imm_bits | w_fields;

    assign in_ready   = (r_count != 2'd2);
    assign out_valid  = (r_count != 2'd0);
    assign out_addr   = r_mem[r_rd_ptr].addr;
    assign out_instr  = r_mem[r_rd_ptr].instr;
    assign err_sticky = r_err_sticky;
    assign err_code   = r_err_code;

    assign w_accept   = in_valid && in_ready;
    assign w_reject   = w_illegal || w_misaligned || w_range_err;
    assign w_push     = w_accept && !w_reject;
    assign w_pop      = out_valid && out_ready;
    assign w_cur_addr = start ? L_BASE : r_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '{addr: L_BASE, instr: 32'h0};
            end
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_count      <= 2'd0;
            r_addr       <= L_BASE;
            r_err_sticky <= 1'b0;
            r_err_code   <= ERR_NONE;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= '{addr: w_cur_addr, instr: w_instr};
                r_wr_ptr        <= ~r_wr_ptr;
                r_addr          <= w_cur_addr + 1'b1;
            end else if (start) begin
                r_addr <= L_BASE;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};

            if (start) begin
                r_err_sticky <= 1'b0;
            end
            if (w_accept && w_reject) begin
                r_err_sticky <= 1'b1;
                if (w_illegal) begin
                    r_err_code <= ERR_ILLEGAL;
                end else if (w_misaligned) begin
                    r_err_code <= ERR_MISALIGN;
                end else begin
                    r_err_code <= ERR_RANGE;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder against a queue-based reference model.
module tb_instr_encoder;

    localparam int ADDR_W = 10;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       instr;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [3:0]        in_class = '0;
    logic [2:0]        in_funct3 = '0;
    logic              in_funct7b5 = 1'b0;
    logic [4:0]        in_rd = '0;
    logic [4:0]        in_rs1 = '0;
    logic [4:0]        in_rs2 = '0;
    logic [31:0]       in_imm = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ADDR_W-1:0] out_addr;
    logic [31:0]       out_instr;
    logic              err_sticky;
    logic [1:0]        err_code;

    int n_checks = 0;
    int n_fail   = 0;
    int cycles   = 0;

    exp_t              m_q[$];
    logic [ADDR_W-1:0] m_cnt;
    logic              m_sticky;
    logic [1:0]        m_code;
    bit                acc;

    instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_instr(out_instr),
        .err_sticky(err_sticky), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // Reference encoding straight from the RV32I format tables.
    function automatic logic [31:0] ref_encode(input logic [3:0] c, input logic [2:0] f3, input logic b5,
                                               input logic [4:0] rd, input logic [4:0] rs1,
                                               input logic [4:0] rs2, input logic [31:0] imm);
        logic [6:0] f7;
        f7 = b5 ? 7'b0100000 : 7'b0000000;
        case (c)
            4'd0: return {imm[11:0], rs1, f3, rd, 7'b0000011};
            4'd1: return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
            4'd2: return {f7, rs2, rs1, f3, rd, 7'b0110011};
            4'd3: return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
            4'd4: begin
                if (f3 == 3'd1 || f3 == 3'd5) return {f7, imm[4:0], rs1, f3, rd, 7'b0010011};
                return {imm[11:0], rs1, f3, rd, 7'b0010011};
            end
            4'd5: return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
            4'd6: return {imm[31:12], rd, 7'b0010111};
            4'd7: return {imm[31:12], rd, 7'b0110111};
            4'd8: return {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [1:0] ref_reject(input logic [3:0] c, input logic [31:0] imm);
        int s;
        s = imm;
        if (c > 4'd8) return 2'b01;
        if ((c == 4'd3 || c == 4'd5) && imm[0]) return 2'b10;
`ifdef IMM_RANGE_CHECK_EN
        case (c)
            4'd0, 4'd1, 4'd4, 4'd8: if (s < -2048 || s > 2047) return 2'b11;
            4'd3: if (s < -4096 || s > 4094) return 2'b11;
            4'd5: if (s < -(1 << 20) || s > (1 << 20) - 2) return 2'b11;
            4'd6, 4'd7: if (imm[11:0] != 12'h0) return 2'b11;
            default: ;
        endcase
`endif
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_cnt    = '0;
        m_sticky = 1'b0;
        m_code   = 2'b00;
    endtask

    // Advances the model by one clock using its own view of FIFO occupancy, then steps past the edge.
    task automatic tick(output bit accepted);
        bit         pop;
        logic [1:0] rc;
        exp_t       e;
        accepted = in_valid && (m_q.size() < 2);
        pop      = out_ready && (m_q.size() > 0);
        rc       = ref_reject(in_class, in_imm);
        if (pop) void'(m_q.pop_front());
        if (start) begin
            m_cnt    = '0;
            m_sticky = 1'b0;
        end
        if (accepted) begin
            if (rc != 2'b00) begin
                m_sticky = 1'b1;
                m_code   = rc;
            end else begin
                e.addr  = m_cnt;
                e.instr = ref_encode(in_class, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2, in_imm);
                m_q.push_back(e);
                m_cnt = m_cnt + 1'b1;
            end
        end
        cycles++;
        if (cycles > 60000) begin
            $display("FAIL cycle_budget: got %0d cycles, required at most 60000", cycles);
            $fatal(1, "cycle budget exhausted");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [3:0] c, input logic [2:0] f3, input logic b5, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        in_class = c; in_funct3 = f3; in_funct7b5 = b5;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_fields(4'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        n_checks++; if (out_addr !== '0) begin n_fail++; $display("FAIL reset_out_addr: got %h required 0", out_addr); end
        n_checks++; if (out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_out_instr: got %h required 0", out_instr); end
        n_checks++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_err_sticky: got %b required 0", err_sticky); end
        n_checks++; if (err_code !== 2'b00) begin n_fail++; $display("FAIL reset_err_code: got %b required 00", err_code); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_vectors();
        logic [3:0]  v_cls [5] = '{4'd4, 4'd7, 4'd1, 4'd3, 4'd5};
        logic [31:0] v_imm [5] = '{32'd5, 32'h12345000, 32'd4, 32'hFFFFFFFC, 32'd8};
        logic [31:0] v_exp [5] = '{32'h00500093, 32'h123452B7, 32'h0021A223, 32'hFE208EE3, 32'h008000EF};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            // Fields a format ignores get random values; the used ones are pinned below.
            set_fields(v_cls[i], 3'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), v_imm[i]);
            case (i)
                0: begin in_rd = 5'd1; in_rs1 = 5'd0; in_funct3 = 3'd0; end
                1: in_rd = 5'd5;
                2: begin in_rs1 = 5'd3; in_rs2 = 5'd2; in_funct3 = 3'd2; end
                3: begin in_rs1 = 5'd1; in_rs2 = 5'd2; in_funct3 = 3'd0; end
                default: in_rd = 5'd1;
            endcase
            in_valid = 1'b1;
            tick(acc);
            in_valid = 1'b0;
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL vec%0d_valid: got %b required 1", i, out_valid); end
            n_checks++; if (out_instr !== v_exp[i]) begin n_fail++; $display("FAIL vec%0d_instr: got %h required %h", i, out_instr, v_exp[i]); end
            n_checks++; if (out_addr !== ADDR_W'(i)) begin n_fail++; $display("FAIL vec%0d_addr: got %0d required %0d", i, out_addr, i); end
            tick(acc);
        end
    endtask

    task automatic test_back_to_back();
        exp_t exp_w [3];
        int   got;
        out_ready = 1'b0;
        start = 1'b1; tick(acc); start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_fields(4'd4, 3'd0, 1'b0, 5'(k + 1), 5'(k + 7), 5'd0, 32'(k * 37 + 1));
            in_valid = 1'b1;
            exp_w[k].addr  = ADDR_W'(k);
            exp_w[k].instr = ref_encode(4'd4, 3'd0, 1'b0, 5'(k + 1), 5'(k + 7), 5'd0, 32'(k * 37 + 1));
            @(negedge clk);
            n_checks++; if (in_ready !== (k < 2)) begin n_fail++; $display("FAIL bp_in_ready_%0d: got %b required %b", k, in_ready, k < 2); end
            tick(acc);
        end
        for (int h = 0; h < 2; h++) begin
            @(negedge clk);
            n_checks++; if ({out_valid, out_addr, out_instr} !== {1'b1, exp_w[0].addr, exp_w[0].instr}) begin
                n_fail++; $display("FAIL bp_hold_%0d: got %b/%h/%h required 1/%h/%h", h, out_valid, out_addr, out_instr, exp_w[0].addr, exp_w[0].instr);
            end
            tick(acc);
        end
        out_ready = 1'b1;
        got = 0;
        for (int t = 0; t < 12 && got < 3; t++) begin
            @(negedge clk);
            if (out_valid) begin
                n_checks++; if ({out_addr, out_instr} !== {exp_w[got].addr, exp_w[got].instr}) begin
                    n_fail++; $display("FAIL bp_drain_%0d: got %h/%h required %h/%h", got, out_addr, out_instr, exp_w[got].addr, exp_w[got].instr);
                end
                got++;
            end
            tick(acc);
            if (acc) in_valid = 1'b0;
        end
        n_checks++; if (got !== 3) begin n_fail++; $display("FAIL bp_drain_count: got %0d words required 3", got); end
        in_valid = 1'b0;
    endtask

    task automatic test_errors();
        out_ready = 1'b1;
        start = 1'b1; tick(acc); start = 1'b0;
        set_fields(4'd12, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0);
        in_valid = 1'b1; tick(acc); in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if ({err_sticky, err_code, out_valid} !== 4'b1010) begin
            n_fail++; $display("FAIL err_illegal: got sticky=%b code=%b valid=%b required 1/01/0", err_sticky, err_code, out_valid);
        end
        set_fields(4'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd7);
        in_valid = 1'b1; tick(acc); in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if ({err_sticky, err_code, out_valid} !== 4'b1100) begin
            n_fail++; $display("FAIL err_misaligned: got sticky=%b code=%b valid=%b required 1/10/0", err_sticky, err_code, out_valid);
        end
        set_fields(4'd4, 3'd0, 1'b0, 5'd2, 5'd1, 5'd0, 32'd9);
        in_valid = 1'b1; tick(acc); in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if ({out_valid, out_addr, err_sticky} !== {1'b1, ADDR_W'(0), 1'b1}) begin
            n_fail++; $display("FAIL err_counter_held: got valid=%b addr=%0d sticky=%b required 1/0/1", out_valid, out_addr, err_sticky);
        end
        tick(acc);
        start = 1'b1; tick(acc); start = 1'b0;
        @(negedge clk);
        n_checks++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL err_start_clear: got %b required 0", err_sticky); end
        tick(acc);
    endtask

    task automatic test_start_same_cycle();
        logic [ADDR_W-1:0] xa;
        out_ready = 1'b1;
        set_fields(4'd4, 3'd0, 1'b0, 5'd3, 5'd3, 5'd0, 32'd1);
        in_valid = 1'b1; tick(acc); tick(acc); in_valid = 1'b0;
        tick(acc); tick(acc);
        out_ready = 1'b0;
        xa = m_cnt;
        in_valid = 1'b1; tick(acc);
        set_fields(4'd7, 3'd0, 1'b0, 5'd4, 5'd0, 5'd0, 32'hABCDE000);
        start = 1'b1; tick(acc); start = 1'b0; in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (out_addr !== xa) begin n_fail++; $display("FAIL start_keeps_queued: got %0d required %0d", out_addr, xa); end
        tick(acc);
        @(negedge clk);
        n_checks++; if ({out_addr, out_instr} !== {ADDR_W'(0), 32'hABCDE237}) begin
            n_fail++; $display("FAIL start_same_word: got %0d/%h required 0/abcde237", out_addr, out_instr);
        end
        tick(acc);
        set_fields(4'd2, 3'd5, 1'b1, 5'd6, 5'd7, 5'd8, 32'd0);
        in_valid = 1'b1; tick(acc); in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if ({out_valid, out_addr, out_instr} !== {1'b1, ADDR_W'(1), 32'h4083D333}) begin
            n_fail++; $display("FAIL start_next_addr: got %b/%0d/%h required 1/1/4083d333", out_valid, out_addr, out_instr);
        end
        tick(acc);
    endtask

    task automatic test_range();
        out_ready = 1'b1;
        set_fields(4'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048);
        in_valid = 1'b1; tick(acc); in_valid = 1'b0;
        @(negedge clk);
`ifdef IMM_RANGE_CHECK_EN
        n_checks++; if ({out_valid, err_sticky, err_code} !== 4'b0111) begin
            n_fail++; $display("FAIL range_itype: got valid=%b sticky=%b code=%b required 0/1/11", out_valid, err_sticky, err_code);
        end
`else
        n_checks++; if ({out_valid, out_instr} !== {1'b1, 32'h80000093}) begin
            n_fail++; $display("FAIL range_itype_trunc: got %b/%h required 1/80000093", out_valid, out_instr);
        end
`endif
        tick(acc);
        set_fields(4'd3, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd4096);
        in_valid = 1'b1; tick(acc); in_valid = 1'b0;
        @(negedge clk);
`ifdef IMM_RANGE_CHECK_EN
        n_checks++; if ({out_valid, err_code} !== 3'b011) begin
            n_fail++; $display("FAIL range_branch: got valid=%b code=%b required 0/11", out_valid, err_code);
        end
`else
        n_checks++; if ({out_valid, out_instr} !== {1'b1, 32'h80000063}) begin
            n_fail++; $display("FAIL range_branch_trunc: got %b/%h required 1/80000063", out_valid, out_instr);
        end
`endif
        tick(acc);
    endtask

    task automatic test_wrap();
        logic [ADDR_W-1:0] ea;
        int seen;
        ea = '0; seen = 0;
        out_ready = 1'b1;
        start = 1'b1; in_valid = 1'b0; tick(acc); start = 1'b0;
        set_fields(4'd0, 3'd2, 1'b0, 5'd9, 5'd4, 5'd0, 32'hFFFFFFF0);
        for (int c = 0; c < 1032; c++) begin
            in_valid = (c < 1030);
            @(negedge clk);
            if (out_valid) begin
                n_checks++; if (out_addr !== ea) begin n_fail++; $display("FAIL wrap_addr_%0d: got %0d required %0d", seen, out_addr, ea); end
                ea = ea + 1'b1;
                seen++;
            end
            tick(acc);
        end
        n_checks++; if (seen !== 1030) begin n_fail++; $display("FAIL wrap_count: got %0d words required 1030", seen); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            start     = ($urandom_range(0, 31) == 0);
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 9) < 7);
            set_fields(($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8)),
                       3'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                       $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 8191)) - 32'd4096);
            @(negedge clk);
            n_checks++; if (in_ready !== (m_q.size() < 2)) begin n_fail++; $display("FAIL rnd_in_ready @%0d: got %b required %b", i, in_ready, m_q.size() < 2); end
            n_checks++; if (out_valid !== (m_q.size() > 0)) begin n_fail++; $display("FAIL rnd_out_valid @%0d: got %b required %b", i, out_valid, m_q.size() > 0); end
            if (m_q.size() > 0) begin
                n_checks++; if ({out_addr, out_instr} !== {m_q[0].addr, m_q[0].instr}) begin
                    n_fail++; $display("FAIL rnd_word @%0d: got %h/%h required %h/%h", i, out_addr, out_instr, m_q[0].addr, m_q[0].instr);
                end
            end
            n_checks++; if ({err_sticky, err_code} !== {m_sticky, m_code}) begin
                n_fail++; $display("FAIL rnd_err @%0d: got %b/%b required %b/%b", i, err_sticky, err_code, m_sticky, m_code);
            end
            tick(acc);
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) tick(acc);
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        set_fields(4'd15, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        in_valid = 1'b1; tick(acc);
        set_fields(4'd6, 3'd0, 1'b0, 5'd10, 5'd0, 5'd0, 32'hFFFFF000);
        tick(acc); tick(acc); in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if ({out_valid, in_ready, err_sticky} !== 3'b101) begin
            n_fail++; $display("FAIL arst_pre: got valid=%b ready=%b sticky=%b required 1/0/1", out_valid, in_ready, err_sticky);
        end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({out_valid, in_ready, out_addr, out_instr, err_sticky, err_code} !== {1'b0, 1'b1, ADDR_W'(0), 32'h0, 1'b0, 2'b00}) begin
            n_fail++; $display("FAIL arst_immediate: got valid=%b ready=%b addr=%0d instr=%h sticky=%b code=%b required 0/1/0/0/0/00",
                               out_valid, in_ready, out_addr, out_instr, err_sticky, err_code);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        out_ready = 1'b1;
        set_fields(4'd8, 3'd7, 1'b0, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF);
        in_valid = 1'b1; tick(acc); in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if ({out_valid, out_addr, out_instr} !== {1'b1, ADDR_W'(0), 32'hFFF100E7}) begin
            n_fail++; $display("FAIL arst_after: got %b/%0d/%h required 1/0/fff100e7", out_valid, out_addr, out_instr);
        end
        tick(acc);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_vectors();
        test_back_to_back();
        test_errors();
        test_start_same_cycle();
        test_range();
        test_wrap();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
